tri_side_gen: RTL

TRI_SIDE_GEN -- requirements
Module: tri_side_gen

---
 rtl/tri_pkg.sv | 17 +
 rtl/tri_side_gen_isqrt_seq.sv | 89 ++++++++
 rtl/tri_side_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// Shared definitions for the triangle side-length generator: widths,
// square-root iteration count and the control FSM state type.
package tri_pkg;

  localparam int COORD_W   = 16;
  localparam int SIDE_W    = COORD_W + 1;
  localparam int RAD_W     = 2 * COORD_W + 2;
  localparam int SQRT_ITER = SIDE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SQRT = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

endpackage

// File: rtl/tri_side_gen_isqrt_seq.sv
// Bit-serial restoring integer square root: floor(sqrt(rad_i)).
// A start pulse while idle latches the radicand, ITERS cycles of one
// root bit each follow, and done_o pulses for one cycle with root_o final.
module isqrt_seq #(
  parameter int RAD_W  = tri_pkg::RAD_W,
  parameter int ROOT_W = tri_pkg::SIDE_W,
  parameter int ITERS  = tri_pkg::SQRT_ITER
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [RAD_W-1:0]  rad_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROOT_W-1:0] root_o
);

  localparam int RemW  = ROOT_W + 3;
  localparam int RemQW = ROOT_W + 1;
  localparam int CntW  = $clog2(ITERS + 1);

  logic [RAD_W-1:0]  radSh_q, radSh_d;
  logic [RemQW-1:0]  rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [CntW-1:0]   iter_q, iter_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RemW-1:0]   remShift;
  logic [RemW-1:0]   trial;

  // One restoring step per busy cycle: pull in the next two radicand bits
  // and keep the trial subtraction only when it does not go negative.
  always_comb begin
    remShift = {rem_q, radSh_q[RAD_W-1 -: 2]};
    trial    = RemW'({root_q, 2'b01});
    radSh_d  = radSh_q;
    rem_d    = rem_q;
    root_d   = root_q;
    iter_d   = iter_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i && !busy_q) begin
      radSh_d = rad_i;
      rem_d   = '0;
      root_d  = '0;
      iter_d  = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      radSh_d = radSh_q << 2;
      if (remShift >= trial) begin
        rem_d  = RemQW'(remShift - trial);
        root_d = {root_q[ROOT_W-2:0], 1'b1};
      end else begin
        rem_d  = RemQW'(remShift);
        root_d = {root_q[ROOT_W-2:0], 1'b0};
      end
      if (iter_q == CntW'(ITERS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        iter_d = iter_q + CntW'(1);
      end
    end
  end

  // Iteration state registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      radSh_q <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      radSh_q <= radSh_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign root_o = root_q;

endmodule

// File: rtl/tri_side_gen.sv
// Triangle side-length generator: collects six coordinates, computes the
// three side lengths with one shared sequential square root, then streams
// the coordinates followed by a, b, c to the incenter stage.
module tri_side_gen #(
  parameter int COORD_W = tri_pkg::COORD_W,
  parameter int SIDE_W  = tri_pkg::SIDE_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [COORD_W-1:0] IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [SIDE_W-1:0]  OUT_DATA,
  output logic               OUT_VALID
);

  import tri_pkg::*;

  localparam int RadW = 2 * SIDE_W;

  state_e             state_q, state_d;
  logic [2:0]         wordCnt_q, wordCnt_d;
  logic [1:0]         startIdx_q, startIdx_d;
  logic [1:0]         doneIdx_q, doneIdx_d;
  logic [3:0]         emitIdx_q, emitIdx_d;
  logic [COORD_W-1:0] coord_q [6];
  logic [COORD_W-1:0] coord_d [6];
  logic [SIDE_W-1:0]  side_q [3];
  logic [SIDE_W-1:0]  side_d [3];
  logic [SIDE_W-1:0]  outData_q, outData_d;
  logic               outValid_q, outValid_d;

  logic               accept;
  logic               sqrtStart;
  logic               sqrtBusy;
  logic               sqrtDone;
  logic [RadW-1:0]    radicand;
  logic [SIDE_W-1:0]  sqrtRoot;
  logic [SIDE_W-1:0]  emitWord;

  // Squared Euclidean distance between two points, exact (no truncation).
  function automatic logic [RadW-1:0] distSq(input logic [COORD_W-1:0] xa,
                                             input logic [COORD_W-1:0] ya,
                                             input logic [COORD_W-1:0] xb,
                                             input logic [COORD_W-1:0] yb);
    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W-1:0]      ax, ay;
    logic [2*COORD_W-1:0]    sx, sy;
    dx = $signed({1'b0, xa}) - $signed({1'b0, xb});
    dy = $signed({1'b0, ya}) - $signed({1'b0, yb});
    ax = dx[COORD_W] ? COORD_W'(-dx) : COORD_W'(dx);
    ay = dy[COORD_W] ? COORD_W'(-dy) : COORD_W'(dy);
    sx = {{COORD_W{1'b0}}, ax} * {{COORD_W{1'b0}}, ax};
    sy = {{COORD_W{1'b0}}, ay} * {{COORD_W{1'b0}}, ay};
    distSq = RadW'(sx) + RadW'(sy);
  endfunction

  assign IN_READY  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = IN_VALID && IN_READY;
  assign sqrtStart = (state_q == ST_SQRT) && !sqrtBusy && (startIdx_q != 2'd3);
  assign OUT_DATA  = outData_q;
  assign OUT_VALID = outValid_q;

  // Radicand for the side about to be started: a=P2P3, b=P1P3, c=P1P2.
  always_comb begin
    radicand = '0;
    case (startIdx_q)
      2'd0:    radicand = distSq(coord_q[2], coord_q[3], coord_q[4], coord_q[5]);
      2'd1:    radicand = distSq(coord_q[0], coord_q[1], coord_q[4], coord_q[5]);
      2'd2:    radicand = distSq(coord_q[0], coord_q[1], coord_q[2], coord_q[3]);
      default: radicand = '0;
    endcase
  end

  // Output word selected by the emit position: six coordinates, then sides.
  always_comb begin
    emitWord = '0;
    case (emitIdx_q)
      4'd1:    emitWord = SIDE_W'(coord_q[1]);
      4'd2:    emitWord = SIDE_W'(coord_q[2]);
      4'd3:    emitWord = SIDE_W'(coord_q[3]);
      4'd4:    emitWord = SIDE_W'(coord_q[4]);
      4'd5:    emitWord = SIDE_W'(coord_q[5]);
      4'd6:    emitWord = side_q[0];
      4'd7:    emitWord = side_q[1];
      4'd8:    emitWord = side_q[2];
      default: emitWord = '0;
    endcase
  end

  // Frame control: load six words, run three square roots back to back,
  // then stream nine words; the output register is zero outside EMIT.
  always_comb begin
    state_d    = state_q;
    wordCnt_d  = wordCnt_q;
    startIdx_d = startIdx_q;
    doneIdx_d  = doneIdx_q;
    emitIdx_d  = emitIdx_q;
    coord_d    = coord_q;
    side_d     = side_q;
    outData_d  = '0;
    outValid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          coord_d[0] = IN_DATA;
          wordCnt_d  = 3'd1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          coord_d[wordCnt_q] = IN_DATA;
          if (wordCnt_q == 3'd5) begin
            wordCnt_d  = 3'd0;
            startIdx_d = 2'd0;
            doneIdx_d  = 2'd0;
            state_d    = ST_SQRT;
          end else begin
            wordCnt_d = wordCnt_q + 3'd1;
          end
        end
      end
      ST_SQRT: begin
        if (sqrtStart) begin
          startIdx_d = startIdx_q + 2'd1;
        end
        if (sqrtDone) begin
          side_d[doneIdx_q] = sqrtRoot;
          doneIdx_d = doneIdx_q + 2'd1;
          if (doneIdx_q == 2'd2) begin
            state_d    = ST_EMIT;
            outValid_d = 1'b1;
            outData_d  = SIDE_W'(coord_q[0]);
            emitIdx_d  = 4'd1;
          end
        end
      end
      ST_EMIT: begin
        if (emitIdx_q == 4'd9) begin
          emitIdx_d = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          outValid_d = 1'b1;
          outData_d  = emitWord;
          emitIdx_d  = emitIdx_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      wordCnt_q  <= '0;
      startIdx_q <= '0;
      doneIdx_q  <= '0;
      emitIdx_q  <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      for (int i = 0; i < 6; i++) coord_q[i] <= '0;
      for (int i = 0; i < 3; i++) side_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wordCnt_q  <= wordCnt_d;
      startIdx_q <= startIdx_d;
      doneIdx_q  <= doneIdx_d;
      emitIdx_q  <= emitIdx_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      coord_q    <= coord_d;
      side_q     <= side_d;
    end
  end

  isqrt_seq #(
    .RAD_W (RadW),
    .ROOT_W(SIDE_W),
    .ITERS (SIDE_W)
  ) uSqrt (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .start_i(sqrtStart),
    .rad_i  (radicand),
    .busy_o (sqrtBusy),
    .done_o (sqrtDone),
    .root_o (sqrtRoot)
  );

endmodule
